// File: rtl/icache_miss_handler.sv
// icache_miss_handler: refill engine for instruction-cache misses.
// Queues missing line addresses in a small FIFO, drops duplicates of lines
// already queued or in flight, fetches each line as a BEATS-beat burst with
// one outstanding request, and returns the assembled line as a 1-cycle fill.
//
// Ports:
//   clk, rst                  clock, async active-low reset
//   miss_valid/addr/ready     miss intake (ready = !full, low in reset)
//   mem_req/addr, mem_gnt     read request, held until granted
//   mem_rvalid/rdata          response beats, in order, gaps allowed
//   fill_valid/addr/line      one-cycle line fill, beat 0 in the LSBs
//   busy                      any FIFO entry valid
module icache_miss_handler #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int BEATS  = 4,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       miss_valid,
  input  logic [ADDR_W-1:0]          miss_addr,
  output logic                       miss_ready,
  output logic                       mem_req,
  output logic [ADDR_W+$clog2(BEATS)-1:0] mem_addr,
  input  logic                       mem_gnt,
  input  logic                       mem_rvalid,
  input  logic [DATA_W-1:0]          mem_rdata,
  output logic                       fill_valid,
  output logic [ADDR_W-1:0]          fill_addr,
  output logic [BEATS*DATA_W-1:0]    fill_line,
  output logic                       busy
);
  localparam int BW = $clog2(BEATS);
  localparam int PW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {IDLE, REQ, RECV, FILL} state_e;
  state_e state_q, state_d;

  logic [DEPTH-1:0][ADDR_W-1:0] fifo_addr_q;
  logic [DEPTH-1:0]             fifo_vld_q;
  logic [PW-1:0]                wptr_q, rptr_q;

  logic [BW-1:0]                    beat_q, beat_d;
  logic [ADDR_W-1:0]                addr_q, addr_d;
  logic [ADDR_W-1:0]                fill_addr_q, fill_addr_d;
  // Beats 0..BEATS-2 are staged here; the last beat goes straight into the
  // output line so fill_line only changes when a new fill is produced.
  logic [BEATS-2:0][DATA_W-1:0]     buf_q, buf_d;
  logic [BEATS-1:0][DATA_W-1:0]     line_q, line_d;

  logic full, empty, dup, push, pop;
  logic [DEPTH-1:0] hit;

  assign full  = (wptr_q[PW-1] != rptr_q[PW-1]) && (wptr_q[PW-2:0] == rptr_q[PW-2:0]);
  assign empty = (wptr_q == rptr_q);

  // Head stays valid until its fill, so in-flight and same-cycle-fill lines
  // are also caught here.
  for (genvar i = 0; i < DEPTH; i++) begin : g_hit
    assign hit[i] = fifo_vld_q[i] && (fifo_addr_q[i] == miss_addr);
  end
  assign dup = |hit;

  assign miss_ready = rst && !full;
  assign push       = miss_valid && miss_ready && !dup;
  assign pop        = (state_q == FILL);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fifo_vld_q  <= '0;
      fifo_addr_q <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
    end else begin
      if (pop) begin
        fifo_vld_q[rptr_q[PW-2:0]] <= 1'b0;
        rptr_q <= rptr_q + 1'b1;
      end
      if (push) begin
        fifo_vld_q[wptr_q[PW-2:0]]  <= 1'b1;
        fifo_addr_q[wptr_q[PW-2:0]] <= miss_addr;
        wptr_q <= wptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      addr_q      <= '0;
      fill_addr_q <= '0;
      buf_q       <= '0;
      line_q      <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      addr_q      <= addr_d;
      fill_addr_q <= fill_addr_d;
      buf_q       <= buf_d;
      line_q      <= line_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    addr_d      = addr_q;
    fill_addr_d = fill_addr_q;
    buf_d       = buf_q;
    line_d      = line_q;
    unique case (state_q)
      IDLE: if (!empty) begin
        addr_d  = fifo_addr_q[rptr_q[PW-2:0]];
        state_d = REQ;
      end
      REQ: if (mem_gnt) begin
        beat_d  = '0;
        state_d = RECV;
      end
      RECV: if (mem_rvalid) begin
        beat_d = beat_q + 1'b1;
        if (beat_q == BW'(BEATS-1)) begin
          line_d      = {mem_rdata, buf_q};
          fill_addr_d = addr_q;
          state_d     = FILL;
        end else begin
          buf_d[beat_q] = mem_rdata;
        end
      end
      FILL: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign mem_req    = (state_q == REQ);
  assign mem_addr   = {addr_q, {BW{1'b0}}};
  assign fill_valid = (state_q == FILL);
  assign fill_addr  = fill_addr_q;
  assign fill_line  = line_q;
  assign busy       = |fifo_vld_q;
endmodule

// File: tb/tb_icache_miss_handler.sv
// Bench for icache_miss_handler: table of single-line refills plus
// hand-written duplicate, full-FIFO and mid-burst-reset sequences. Expected
// fills go into a scoreboard queue when a miss is driven and are popped by a
// monitor when fill_valid is seen.
module tb_icache_miss_handler;
  logic         clk = 1'b0;
  logic         rst;
  logic         miss_valid;
  logic [15:0]  miss_addr;
  logic         miss_ready;
  logic         mem_req;
  logic [17:0]  mem_addr;
  logic         mem_gnt;
  logic         mem_rvalid;
  logic [31:0]  mem_rdata;
  logic         fill_valid;
  logic [15:0]  fill_addr;
  logic [127:0] fill_line;
  logic         busy;

  icache_miss_handler dut (
    .clk(clk), .rst(rst),
    .miss_valid(miss_valid), .miss_addr(miss_addr), .miss_ready(miss_ready),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .fill_valid(fill_valid), .fill_addr(fill_addr), .fill_line(fill_line),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct { logic [15:0] addr; logic [127:0] line; } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [15:0]       addr;
    int                gdly;
    int                gap;
    logic [3:0][31:0]  beats;
    logic [127:0]      line;
  } vec_t;
  vec_t vt[4];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard consumer: every fill must match the oldest expected line.
  always @(negedge clk) begin
    if (rst === 1'b1 && fill_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_fill", {112'h0, fill_addr}, 128'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("fill_addr", {112'h0, fill_addr}, {112'h0, e.addr});
        chk("fill_line", fill_line, e.line);
      end
    end
  end

  function automatic logic [3:0][31:0] mkbeats(input logic [15:0] a);
    logic [3:0][31:0] b;
    for (int k = 0; k < 4; k++) b[k] = {a, 12'h5A0, 4'(k)};
    return b;
  endfunction

  task automatic miss(input logic [15:0] a, input bit expect_push, input logic [3:0][31:0] b);
    exp_t e;
    miss_valid = 1'b1;
    miss_addr  = a;
    if (expect_push) begin
      e.addr = a;
      e.line = b;
      sb.push_back(e);
    end
    tick();
    miss_valid = 1'b0;
  endtask

  // Memory model for one line: wait for request, check address, grant after
  // gdly cycles, return beats with gap idle cycles between them.
  task automatic serve(input logic [15:0] a, input int gdly, input int gap,
                       input logic [3:0][31:0] b);
    int n = 0;
    while (mem_req !== 1'b1 && n < 50) begin tick(); n++; end
    if (mem_req !== 1'b1) begin
      chk("req_timeout", {127'h0, mem_req}, 128'h1);
      return;
    end
    chk("mem_addr", {110'h0, mem_addr}, {110'h0, a, 2'b00});
    for (int i = 0; i < gdly; i++) begin
      tick();
      chk("req_held", {127'h0, mem_req}, 128'h1);
    end
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    for (int k = 0; k < 4; k++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = b[k];
      tick();
      mem_rvalid = 1'b0;
      mem_rdata  = 32'h0;
      if (k < 3) for (int g = 0; g < gap; g++) tick();
    end
    chk("fill_after_last_beat", {127'h0, fill_valid}, 128'h1);
    tick();
    chk("fill_one_cycle", {127'h0, fill_valid}, 128'h0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_miss_ready"}, {127'h0, miss_ready}, 128'h0);
    chk({tag, "_mem_req"},    {127'h0, mem_req},    128'h0);
    chk({tag, "_mem_addr"},   {110'h0, mem_addr},   128'h0);
    chk({tag, "_fill_valid"}, {127'h0, fill_valid}, 128'h0);
    chk({tag, "_fill_addr"},  {112'h0, fill_addr},  128'h0);
    chk({tag, "_fill_line"},  fill_line,            128'h0);
    chk({tag, "_busy"},       {127'h0, busy},       128'h0);
  endtask

  initial begin
    vt[0] = '{16'h0123, 0, 0, {32'h000000A3, 32'h000000A2, 32'h000000A1, 32'h000000A0},
              128'h000000A3_000000A2_000000A1_000000A0};
    vt[1] = '{16'hFFFF, 2, 0, {32'hFFFFFFFF, 32'h89ABCDEF, 32'h01234567, 32'hDEADBEEF},
              128'hFFFFFFFF_89ABCDEF_01234567_DEADBEEF};
    vt[2] = '{16'h0000, 1, 3, {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111},
              128'h44444444_33333333_22222222_11111111};
    vt[3] = '{16'h8001, 0, 1, {32'h80000001, 32'h00000000, 32'h00000000, 32'h00000000},
              128'h80000001_00000000_00000000_00000000};

    // Reset with random inputs.
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      miss_valid = 1'($urandom);
      miss_addr  = 16'($urandom);
      mem_gnt    = 1'($urandom);
      mem_rvalid = 1'($urandom);
      mem_rdata  = $urandom;
      tick();
      check_reset_outputs("rst");
    end
    miss_valid = 1'b0; miss_addr = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    rst = 1'b1;
    #1;
    chk("rel_miss_ready", {127'h0, miss_ready}, 128'h1);
    chk("rel_busy", {127'h0, busy}, 128'h0);
    tick();

    // Table-driven single-line refills.
    for (int v = 0; v < 4; v++) begin
      miss(vt[v].addr, 1'b1, vt[v].line);
      chk("req_not_yet", {127'h0, mem_req}, 128'h0);
      tick();
      chk("req_at_n2", {127'h0, mem_req}, 128'h1);
      serve(vt[v].addr, vt[v].gdly, vt[v].gap, vt[v].beats);
      chk("busy_after_fill", {127'h0, busy}, 128'h0);
      chk("fill_line_holds", fill_line, vt[v].line);
    end

    // Duplicate drop: 0x0010 x3 then 0x0020 -> two requests in order.
    miss(16'h0010, 1'b1, mkbeats(16'h0010));
    miss(16'h0010, 1'b0, mkbeats(16'h0010));
    miss(16'h0010, 1'b0, mkbeats(16'h0010));
    miss(16'h0020, 1'b1, mkbeats(16'h0020));
    serve(16'h0010, 0, 0, mkbeats(16'h0010));
    serve(16'h0020, 0, 0, mkbeats(16'h0020));
    for (int i = 0; i < 5; i++) tick();
    chk("dup_no_third_req", {127'h0, mem_req}, 128'h0);
    chk("dup_busy", {127'h0, busy}, 128'h0);

    // Full FIFO while the head's grant is stalled.
    for (int i = 0; i < 4; i++) miss(16'h0100 + 16'(i), 1'b1, mkbeats(16'h0100 + 16'(i)));
    chk("full_ready_low", {127'h0, miss_ready}, 128'h0);
    miss_valid = 1'b1; miss_addr = 16'h01FF;
    tick(); tick();
    miss_valid = 1'b0;
    serve(16'h0100, 0, 0, mkbeats(16'h0100));
    chk("ready_after_pop", {127'h0, miss_ready}, 128'h1);
    for (int i = 1; i < 4; i++) serve(16'h0100 + 16'(i), 0, 0, mkbeats(16'h0100 + 16'(i)));
    for (int i = 0; i < 5; i++) tick();
    chk("fifth_not_taken", {127'h0, mem_req}, 128'h0);

    // Mid-burst reset: two beats in, then reset.
    miss(16'h0055, 1'b1, mkbeats(16'h0055));
    tick();
    mem_gnt = 1'b1; tick(); mem_gnt = 1'b0;
    for (int k = 0; k < 2; k++) begin
      mem_rvalid = 1'b1; mem_rdata = 32'hBAD0_0000 + 32'(k); tick();
    end
    mem_rvalid = 1'b0;
    rst = 1'b0;
    sb.delete();
    #1;
    check_reset_outputs("midrst");
    tick();
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      mem_rvalid = 1'b1; mem_rdata = 32'hBAD1_0000 + 32'(k); tick();
      chk("stray_no_fill", {127'h0, fill_valid}, 128'h0);
      chk("stray_no_req", {127'h0, mem_req}, 128'h0);
    end
    mem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("stray_no_fill_late", {127'h0, fill_valid}, 128'h0);
    miss(16'h0077, 1'b1, mkbeats(16'h0077));
    serve(16'h0077, 1, 0, mkbeats(16'h0077));

    tick(); tick();
    chk("sb_drained", 128'(sb.size()), 128'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end
endmodule
